ir_transmitter_sm: RTL

//  Bus-mapped IR remote-control transmitter peripheral, downstream of the processor bus; drives the top-level IR_LED pin.
//  The processor writes a 4-bit drive command; each SEND_PACKET strobe emits one packet.

---
 rtl/ir_transmitter_sm.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ir_transmitter_sm.sv
// ir_transmitter_sm
//   Bus-mapped IR remote-control transmitter. The processor writes a 4-bit
//   drive command at BASE_ADDR. Each SEND_PACKET strobe received while idle
//   sends one packet on IR_LED. A packet is a start burst, a car-select burst
//   and four command-bit bursts (RIGHT, LEFT, BACK, FWD), with a carrier-off
//   gap after every burst. Bursts are modulated by a carrier of CARRIER_DIV
//   clock cycles per period, high for the first half of each period.
//
// Ports
//   CLK          system clock
//   RESET        synchronous, active-high reset
//   BUS_ADDR     processor bus address
//   BUS_DATA     processor write data, only [3:0] is used
//   BUS_WE       bus write enable, qualifies one cycle
//   SEND_PACKET  one-cycle strobe requesting a packet
//   IR_LED       modulated IR output (registered)
//   BUSY         high while a packet is in progress (registered)
module ir_transmitter_sm #(
  parameter logic [7:0]  BASE_ADDR    = 8'h90,
  parameter int unsigned CARRIER_DIV  = 2778,
  parameter int unsigned START_LEN    = 88,
  parameter int unsigned SELECT_LEN   = 22,
  parameter int unsigned GAP_LEN      = 40,
  parameter int unsigned ASSERT_LEN   = 44,
  parameter int unsigned DEASSERT_LEN = 22
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA,
  input  logic       BUS_WE,
  input  logic       SEND_PACKET,
  output logic       IR_LED,
  output logic       BUSY
);

  localparam int unsigned MAX_AB  = (ASSERT_LEN > DEASSERT_LEN) ? ASSERT_LEN : DEASSERT_LEN;
  localparam int unsigned MAX_SS  = (START_LEN > SELECT_LEN) ? START_LEN : SELECT_LEN;
  localparam int unsigned MAX_SG  = (MAX_SS > GAP_LEN) ? MAX_SS : GAP_LEN;
  localparam int unsigned MAX_LEN = (MAX_SG > MAX_AB) ? MAX_SG : MAX_AB;

  localparam int unsigned CW = $clog2(CARRIER_DIV);
  localparam int unsigned PW = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] CARR_LAST = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CARR_HALF = CW'(CARRIER_DIV / 2);

  // Period counters compare against length-1 so the wrap that completes the
  // final period is the one that advances the state.
  localparam logic [PW-1:0] START_LAST    = PW'(START_LEN - 1);
  localparam logic [PW-1:0] SELECT_LAST   = PW'(SELECT_LEN - 1);
  localparam logic [PW-1:0] GAP_LAST      = PW'(GAP_LEN - 1);
  localparam logic [PW-1:0] ASSERT_LAST   = PW'(ASSERT_LEN - 1);
  localparam logic [PW-1:0] DEASSERT_LAST = PW'(DEASSERT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GAP,
    S_SELECT,
    S_RIGHT,
    S_LEFT,
    S_BACK,
    S_FWD
  } state_t;

  state_t          state_q, state_d;
  state_t          ret_q, ret_d;        // state entered when the current gap ends
  logic [3:0]      cmd_q, cmd_d;        // bus-visible command register
  logic [3:0]      snap_q, snap_d;      // command frozen for the packet in flight
  logic [CW-1:0]   carr_cnt_q, carr_cnt_d;
  logic [PW-1:0]   per_cnt_q, per_cnt_d;
  logic            led_q, led_d;
  logic            busy_q, busy_d;

  logic [PW-1:0]   cur_last;
  logic            burst_d;

  logic            unused_data;
  assign unused_data = ^BUS_DATA[7:4];

  // Length (minus one) of the state currently running.
  always_comb begin
    cur_last = '0;
    case (state_q)
      S_START:  cur_last = START_LAST;
      S_SELECT: cur_last = SELECT_LAST;
      S_GAP:    cur_last = GAP_LAST;
      S_RIGHT:  cur_last = snap_q[3] ? ASSERT_LAST : DEASSERT_LAST;
      S_LEFT:   cur_last = snap_q[2] ? ASSERT_LAST : DEASSERT_LAST;
      S_BACK:   cur_last = snap_q[1] ? ASSERT_LAST : DEASSERT_LAST;
      S_FWD:    cur_last = snap_q[0] ? ASSERT_LAST : DEASSERT_LAST;
      default:  cur_last = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cmd_d      = cmd_q;
    snap_d     = snap_q;
    carr_cnt_d = carr_cnt_q;
    per_cnt_d  = per_cnt_q;

    if (BUS_WE && (BUS_ADDR == BASE_ADDR)) begin
      cmd_d = BUS_DATA[3:0];
    end

    if (state_q == S_IDLE) begin
      carr_cnt_d = '0;
      per_cnt_d  = '0;
      if (SEND_PACKET) begin
        state_d = S_START;
        // Snapshot reads the register before any same-cycle write lands.
        snap_d  = cmd_q;
      end
    end else if (carr_cnt_q == CARR_LAST) begin
      carr_cnt_d = '0;
      if (per_cnt_q == cur_last) begin
        per_cnt_d = '0;
        case (state_q)
          S_START:  begin state_d = S_GAP; ret_d = S_SELECT; end
          S_SELECT: begin state_d = S_GAP; ret_d = S_RIGHT;  end
          S_RIGHT:  begin state_d = S_GAP; ret_d = S_LEFT;   end
          S_LEFT:   begin state_d = S_GAP; ret_d = S_BACK;   end
          S_BACK:   begin state_d = S_GAP; ret_d = S_FWD;    end
          S_FWD:    begin state_d = S_GAP; ret_d = S_IDLE;   end
          S_GAP:    state_d = ret_q;
          default:  state_d = S_IDLE;
        endcase
      end else begin
        per_cnt_d = per_cnt_q + 1'b1;
      end
    end else begin
      carr_cnt_d = carr_cnt_q + 1'b1;
    end

    // Outputs are computed from the next state so that the registered LED
    // and BUSY line up with the state they describe.
    burst_d = (state_d != S_IDLE) && (state_d != S_GAP);
    led_d   = burst_d && (carr_cnt_d < CARR_HALF);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      cmd_q      <= '0;
      snap_q     <= '0;
      carr_cnt_q <= '0;
      per_cnt_q  <= '0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cmd_q      <= cmd_d;
      snap_q     <= snap_d;
      carr_cnt_q <= carr_cnt_d;
      per_cnt_q  <= per_cnt_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  assign IR_LED = led_q;
  assign BUSY   = busy_q;

endmodule
